// File: rtl/light_phase_sequencer.sv
// Traffic light phase sequencer: min-green / yellow / all-red clearance around lane changes.
// Optional MAX_GREEN_EN macro forces a changeover to the next direction after MAX_GREEN cycles.
module light_phase_sequencer #(
  parameter int MIN_GREEN    = 20,
  parameter int YELLOW_TIME  = 4,
  parameter int ALL_RED_TIME = 2,
  parameter int CNT_W        = 8,
  parameter int MAX_GREEN    = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] laneRequest,
  output logic [7:0] green,
  output logic [7:0] yellow,
  output logic [7:0] red,
  output logic [1:0] activeDir,
  output logic       phaseChange
);

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALL_RED_TIME - 1);
  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(YELLOW_TIME - 1);

  if (MIN_GREEN < 1 || YELLOW_TIME < 1 || ALL_RED_TIME < 1 ||
      MAX_GREEN <= MIN_GREEN || MAX_GREEN >= (1 << CNT_W) ||
      MIN_GREEN >= (1 << CNT_W) || YELLOW_TIME >= (1 << CNT_W) ||
      ALL_RED_TIME >= (1 << CNT_W)) begin : g_param_check
    $error("light_phase_sequencer: illegal timing parameters");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cur_q, cur_d;
  logic [1:0]       pend_q, pend_d;
  logic             served_q, served_d;
  logic [7:0]       green_q, green_d;
  logic [7:0]       yellow_q, yellow_d;
  logic [7:0]       red_q;
  logic [1:0]       active_q, active_d;
  logic             phase_q, phase_d;

  logic [7:0] pair_mask [4];
  logic [3:0] req_hit;
  logic       req_valid;
  logic [1:0] req_dir;

  // Lane pair masks and exact-match request decode; anything else is "no request".
  for (genvar gi = 0; gi < 4; gi++) begin : g_pair
    assign pair_mask[gi] = 8'h03 << (2 * gi);
    assign req_hit[gi]   = (laneRequest == pair_mask[gi]);
  end

  assign req_valid = |req_hit;

  always_comb begin
    req_dir = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (req_hit[i]) req_dir = 2'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cur_d    = cur_q;
    pend_d   = pend_q;
    served_d = served_q;
    case (state_q)
      ST_ALL_RED: begin
        if (cnt_q != AR_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else if (served_q) begin
          state_d = ST_GREEN;
          cnt_d   = '0;
          cur_d   = pend_q;
        end else if (req_valid) begin
          state_d = ST_GREEN;
          cnt_d   = '0;
          cur_d   = req_dir;
          pend_d  = req_dir;
        end
      end
      ST_GREEN: begin
`ifdef MAX_GREEN_EN
        if (cnt_q >= MIN_LAST && req_valid && req_dir != cur_q) begin
          state_d = ST_YELLOW;
          cnt_d   = '0;
          pend_d  = req_dir;
        end else if (cnt_q == CNT_W'(MAX_GREEN - 1)) begin
          // Forced rotation N->E->S->W->N regardless of the request.
          state_d = ST_YELLOW;
          cnt_d   = '0;
          pend_d  = cur_q + 2'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`else
        if (cnt_q != MIN_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else if (req_valid && req_dir != cur_q) begin
          state_d = ST_YELLOW;
          cnt_d   = '0;
          pend_d  = req_dir;
        end
`endif
      end
      ST_YELLOW: begin
        if (cnt_q == Y_LAST) begin
          state_d  = ST_ALL_RED;
          cnt_d    = '0;
          served_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_ALL_RED;
        cnt_d   = '0;
      end
    endcase
  end

  // Light outputs are registered from the next state so they change with the state.
  always_comb begin
    green_d  = (state_d == ST_GREEN)  ? pair_mask[cur_d] : 8'h00;
    yellow_d = (state_d == ST_YELLOW) ? pair_mask[cur_d] : 8'h00;
    phase_d  = (state_d == ST_GREEN) && (state_q != ST_GREEN);
    active_d = phase_d ? cur_d : active_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_ALL_RED;
      cnt_q    <= '0;
      cur_q    <= 2'd0;
      pend_q   <= 2'd0;
      served_q <= 1'b0;
      green_q  <= 8'h00;
      yellow_q <= 8'h00;
      red_q    <= 8'hFF;
      active_q <= 2'd0;
      phase_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cur_q    <= cur_d;
      pend_q   <= pend_d;
      served_q <= served_d;
      green_q  <= green_d;
      yellow_q <= yellow_d;
      red_q    <= ~(green_d | yellow_d);
      active_q <= active_d;
      phase_q  <= phase_d;
    end
  end

  assign green       = green_q;
  assign yellow      = yellow_q;
  assign red         = red_q;
  assign activeDir   = active_q;
  assign phaseChange = phase_q;

endmodule

// File: tb/tb_light_phase_sequencer.sv
// Self-checking bench for light_phase_sequencer: directed scenarios plus randomized
// requests against a timeline model (phase ages and changeover elapsed time).
module tb_light_phase_sequencer;

  localparam int MIN_G = 20;
  localparam int YEL   = 4;
  localparam int ARED  = 2;
  localparam int MAXG  = 30;
`ifdef MAX_GREEN_EN
  localparam bit MAXEN = 1'b1;
`else
  localparam bit MAXEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] laneRequest = 8'h00;
  logic [7:0] green, yellow, red;
  logic [1:0] activeDir;
  logic       phaseChange;

  int pass_cnt  = 0;
  int total_cnt = 0;

  light_phase_sequencer #(
    .MIN_GREEN(MIN_G), .YELLOW_TIME(YEL), .ALL_RED_TIME(ARED), .CNT_W(8), .MAX_GREEN(MAXG)
  ) dut (
    .clk(clk), .rst(rst), .laneRequest(laneRequest), .green(green), .yellow(yellow),
    .red(red), .activeDir(activeDir), .phaseChange(phaseChange)
  );

  always #5 clk = ~clk;

  // Model: mode 0 = waiting for first green, 1 = green on m_dir for m_age cycles,
  // 2 = changeover m_from -> m_to, m_age cycles elapsed since green ended.
  int m_mode = 0, m_age = 0, m_dir = 0, m_from = 0, m_to = 0, m_last = 0;
  bit m_pulse = 1'b0;

  function automatic int req_dir(input logic [7:0] r);
    case (r)
      8'h03:   return 0;
      8'h0C:   return 1;
      8'h30:   return 2;
      8'hC0:   return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [7:0] pair_of(input int d);
    logic [7:0] base = 8'h03;
    return base << (2 * d);
  endfunction

  function automatic void start_green(input int d);
    m_mode = 1; m_dir = d; m_age = 0; m_last = d; m_pulse = 1'b1;
  endfunction

  function automatic void model_step(input logic r_rst, input logic [7:0] r_req);
    int d = req_dir(r_req);
    m_pulse = 1'b0;
    if (r_rst) begin
      m_mode = 0; m_age = 0; m_last = 0;
    end else if (m_mode == 0) begin
      if (m_age >= ARED - 1 && d >= 0) start_green(d);
      else m_age++;
    end else if (m_mode == 1) begin
      if (m_age >= MIN_G - 1 && d >= 0 && d != m_dir) begin
        m_mode = 2; m_from = m_dir; m_to = d; m_age = 0;
      end else if (MAXEN && m_age >= MAXG - 1) begin
        m_mode = 2; m_from = m_dir; m_to = (m_dir + 1) % 4; m_age = 0;
      end else begin
        m_age++;
      end
    end else begin
      m_age++;
      if (m_age == YEL + ARED) start_green(m_to);
    end
  endfunction

  function automatic logic [26:0] model_vec();
    logic [7:0] g, y;
    g = (m_mode == 1) ? pair_of(m_dir) : 8'h00;
    y = (m_mode == 2 && m_age < YEL) ? pair_of(m_from) : 8'h00;
    return {g, y, ~(g | y), 2'(m_last), m_pulse};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(rst, laneRequest);
    #1;
  endtask

  task automatic go_green_n();
    rst = 1'b1; laneRequest = 8'h03; tick();
    rst = 1'b0; tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; laneRequest = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if ({green, yellow, red, activeDir, phaseChange} !== {8'h00, 8'h00, 8'hFF, 2'd0, 1'b0})
        $display("FAIL reset_state: got g=%h y=%h r=%h ad=%0d pc=%b want 00/00/FF/0/0",
                 green, yellow, red, activeDir, phaseChange);
      else pass_cnt++;
    end
  endtask

  task automatic test_first_green();
    rst = 1'b0; laneRequest = 8'h03;
    tick();
    total_cnt++;
    if (red !== 8'hFF || green !== 8'h00) $display("FAIL first_edge: got g=%h r=%h want 00/FF", green, red);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({green, red, activeDir, phaseChange} !== {8'h03, 8'hFC, 2'd0, 1'b1})
      $display("FAIL first_green: got g=%h r=%h ad=%0d pc=%b want 03/FC/0/1", green, red, activeDir, phaseChange);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (phaseChange !== 1'b0) $display("FAIL pulse_width: got pc=%b want 0", phaseChange);
    else pass_cnt++;
  endtask

  task automatic test_early_change();
    int n;
    go_green_n();
    n = 0;
    while (green === 8'h03 && n < 200) begin
      if (n == 4) laneRequest = 8'h0C;
      tick(); n++;
    end
    total_cnt++;
    if (n !== MIN_G) $display("FAIL min_green_len: got %0d want %0d", n, MIN_G); else pass_cnt++;
    n = 0;
    while (yellow === 8'h03 && green === 8'h00 && n < 200) begin tick(); n++; end
    total_cnt++;
    if (n !== YEL) $display("FAIL yellow_len: got %0d want %0d", n, YEL); else pass_cnt++;
    n = 0;
    while (red === 8'hFF && n < 200) begin tick(); n++; end
    total_cnt++;
    if (n !== ARED) $display("FAIL all_red_len: got %0d want %0d", n, ARED); else pass_cnt++;
    total_cnt++;
    if ({green, activeDir, phaseChange} !== {8'h0C, 2'd1, 1'b1})
      $display("FAIL green_east: got g=%h ad=%0d pc=%b want 0C/1/1", green, activeDir, phaseChange);
    else pass_cnt++;
  endtask

`ifndef MAX_GREEN_EN
  task automatic test_held_request();
    int pulses, yel_seen, bad_green;
    go_green_n();
    pulses = int'(phaseChange); yel_seen = 0; bad_green = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      pulses += int'(phaseChange);
      if (yellow !== 8'h00) yel_seen++;
      if (green !== 8'h03) bad_green++;
    end
    total_cnt++;
    if (bad_green !== 0 || yel_seen !== 0 || pulses !== 1)
      $display("FAIL held_request: got bad_green=%0d yellow=%0d pulses=%0d want 0/0/1", bad_green, yel_seen, pulses);
    else pass_cnt++;
  endtask
`endif

  task automatic test_invalid();
    logic [7:0] bad_vals [3] = '{8'h00, 8'h01, 8'h0F};
    int errs;
    rst = 1'b1; tick(); rst = 1'b0;
    errs = 0;
    foreach (bad_vals[k]) begin
      laneRequest = bad_vals[k];
      for (int i = 0; i < 5; i++) begin
        tick();
        if (red !== 8'hFF || green !== 8'h00 || yellow !== 8'h00) errs++;
      end
    end
    total_cnt++;
    if (errs !== 0) $display("FAIL invalid_all_red: got %0d bad cycles want 0", errs); else pass_cnt++;
    laneRequest = 8'h03; tick();
    total_cnt++;
    if (green !== 8'h03) $display("FAIL late_request: got g=%h want 03", green); else pass_cnt++;
    errs = 0;
    foreach (bad_vals[k]) begin
      laneRequest = bad_vals[k];
      for (int i = 0; i < 15; i++) begin
        tick();
        if ({green, yellow, red, activeDir, phaseChange} !== model_vec()) errs++;
      end
    end
    total_cnt++;
    if (errs !== 0) $display("FAIL invalid_hold: got %0d bad cycles want 0", errs); else pass_cnt++;
  endtask

  task automatic test_clearance_change();
    int n;
    go_green_n();
    laneRequest = 8'h0C;
    n = 0;
    while (yellow === 8'h00 && n < 200) begin tick(); n++; end
    laneRequest = 8'h30;
    n = 0;
    while (green === 8'h00 && n < 200) begin tick(); n++; end
    total_cnt++;
    if (green !== 8'h0C) $display("FAIL pend_committed: got g=%h want 0C", green); else pass_cnt++;
    n = 0;
    while (green !== 8'h30 && n < 200) begin tick(); n++; end
    total_cnt++;
    if (n !== MIN_G + YEL + ARED) $display("FAIL south_latency: got %0d want %0d", n, MIN_G + YEL + ARED);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_yellow();
    int n;
    go_green_n();
    laneRequest = 8'h0C;
    n = 0;
    while (yellow === 8'h00 && n < 200) begin tick(); n++; end
    tick(); tick();
    total_cnt++;
    if (yellow !== 8'h03) $display("FAIL mid_yellow_setup: got y=%h want 03", yellow); else pass_cnt++;
    rst = 1'b1; tick();
    total_cnt++;
    if ({green, yellow, red} !== {8'h00, 8'h00, 8'hFF})
      $display("FAIL reset_mid_yellow: got g=%h y=%h r=%h want 00/00/FF", green, yellow, red);
    else pass_cnt++;
    rst = 1'b0;
  endtask

`ifdef MAX_GREEN_EN
  task automatic test_max_green();
    int n;
    go_green_n();
    n = 0;
    while (green === 8'h03 && n < 200) begin tick(); n++; end
    total_cnt++;
    if (n !== MAXG) $display("FAIL max_green_len: got %0d want %0d", n, MAXG); else pass_cnt++;
    n = 0;
    while (green !== 8'h0C && n < 200) begin tick(); n++; end
    total_cnt++;
    if (n !== YEL + ARED) $display("FAIL forced_to_east: got %0d want %0d", n, YEL + ARED); else pass_cnt++;
    n = 0;
    while (green === 8'h0C && n < 200) begin tick(); n++; end
    total_cnt++;
    if (n !== MIN_G || yellow !== 8'h0C) $display("FAIL east_preempt: got len=%0d y=%h want %0d/0C", n, yellow, MIN_G);
    else pass_cnt++;
    n = 0;
    while (green !== 8'h03 && n < 200) begin tick(); n++; end
    total_cnt++;
    if (n !== YEL + ARED) $display("FAIL back_to_north: got %0d want %0d", n, YEL + ARED); else pass_cnt++;
  endtask
`endif

  task automatic test_random();
    logic [7:0] r;
    int hold, errs;
    errs = 0;
    for (int i = 0; i < 3000; ) begin
      if ($urandom_range(0, 3) != 0) r = pair_of(int'($urandom_range(0, 3)));
      else r = 8'($urandom);
      hold = int'($urandom_range(1, 30));
      rst = ($urandom_range(0, 59) == 0);
      for (int j = 0; j < hold; j++) begin
        laneRequest = r;
        tick();
        rst = 1'b0;
        i++;
        total_cnt++;
        if ({green, yellow, red, activeDir, phaseChange} !== model_vec()) begin
          errs++;
          if (errs <= 10)
            $display("FAIL random_cycle%0d: got g=%h y=%h r=%h ad=%0d pc=%b want %h", i,
                     green, yellow, red, activeDir, phaseChange, model_vec());
        end else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_green();
    test_early_change();
`ifndef MAX_GREEN_EN
    test_held_request();
`endif
    test_invalid();
    test_clearance_change();
    test_reset_mid_yellow();
`ifdef MAX_GREEN_EN
    test_max_green();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/light_phase_sequencer.md
Name: light_phase_sequencer

Overview:
Downstream stage of the day-time lane selector. Consumes the 8-bit paired one-hot lane request and drives the physical light outputs. Enforces minimum green, yellow and all-red clearance intervals, so a change in the selected direction never switches lights abruptly. All light outputs are registered and mutually exclusive per lane.

Parameters:
MIN_GREEN, 20, minimum cycles a direction stays green before it can be preempted; >=1
YELLOW_TIME, 4, cycles of yellow on the outgoing direction; >=1
ALL_RED_TIME, 2, cycles of all-red clearance before any green; >=1
CNT_W, 8, width of the phase counter; every timing parameter must be < 2^CNT_W
MAX_GREEN, 60, forced-changeover limit; used only with MAX_GREEN_EN; must be > MIN_GREEN

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
laneRequest  in  8  paired one-hot direction request: 8'h03 N, 8'h0C E, 8'h30 S, 8'hC0 W
green  out  8  per-lane green, same bit map as laneRequest
yellow  out  8  per-lane yellow
red  out  8  per-lane red; always equals ~(green|yellow)
activeDir  out  2  direction last given green: 0 N, 1 E, 2 S, 3 W
phaseChange  out  1  one-cycle pulse in the first cycle of each new green

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Valid request: exactly one of 8'h03/8'h0C/8'h30/8'hC0. Any other value, including 0, partial pairs and multiple pairs, is treated as "no request".
- States: ALL_RED, GREEN, YELLOW. Register cnt is CNT_W wide. Registers cur (2b), pend (2b) and served (1b).
- Reset:
  - state=ALL_RED, cnt=0, served=0, cur=0, pend=0.
  - green=0, yellow=0, red=8'hFF, activeDir=0, phaseChange=0.
  - Reset asserted in any state (including mid-yellow) forces this on the next edge.
- Every state is entered with cnt=0.
- ALL_RED:
  - If cnt != ALL_RED_TIME-1: cnt++.
  - Else, if served=1: go to GREEN on pend.
  - Else, if served=0 and the request is valid: latch it into pend and cur, then go to GREEN.
  - Else stay in ALL_RED with cnt held at ALL_RED_TIME-1, so green follows the first valid request on the next edge.
- GREEN on dir d:
  - Outputs green pair d=2'b11; all other lanes red.
  - cnt saturates at MIN_GREEN-1.
  - When cnt==MIN_GREEN-1, the request is valid, and the request is not equal to d: latch pend=request, then go to YELLOW.
  - Otherwise stay in GREEN. An identical request holds green indefinitely. An invalid request holds green.
- YELLOW:
  - Outputs yellow pair cur; others red.
  - After YELLOW_TIME cycles, go to ALL_RED with served=1.
  - Request changes during YELLOW/ALL_RED are ignored; pend is already committed.
- On entry to GREEN: cur<=pend (or the latched request), activeDir<=cur, phaseChange=1 for that single cycle.
- Latencies:
  - Reset release to first green: ALL_RED_TIME edges with rst low, given a valid request.
  - Green-end to next green: YELLOW_TIME+ALL_RED_TIME cycles.
  - Minimum green duration: MIN_GREEN cycles.
- Invariants: at most one pair green or yellow at any time; never green and yellow on the same lane; never green immediately after yellow.

Optional Feature:
MAX_GREEN_EN:
- Defined:
  - GREEN counts up to MAX_GREEN-1 (saturating), with the normal MIN_GREEN preemption rule unchanged.
  - If cnt reaches MAX_GREEN-1 still on d, force YELLOW with pend=(d+1) mod 4 (N->E->S->W->N), regardless of request.
- Undefined: no upper bound on green; MAX_GREEN is ignored.

Test Plan:
1. Reset and first green:
   - Stimulus: rst=1 for 3 cycles, then rst=0 with laneRequest=8'h03.
   - Response: red=8'hFF, green=0 during reset. After 2 edges, green=8'h03 and red=8'hFC. phaseChange pulses once, activeDir=0.
2. Early request change:
   - Stimulus: green N; at green cycle 5, laneRequest=8'h0C.
   - Response: green N persists to 20 total cycles. Then yellow=8'h03 for 4 cycles, red=8'hFF for 2 cycles, then green=8'h0C with activeDir=1.
3. Held request:
   - Stimulus: laneRequest fixed at 8'h03 for 200 cycles (macro off).
   - Response: green=8'h03 throughout; yellow never asserts; single phaseChange.
4. Invalid requests:
   - Stimulus: from reset apply 8'h00, 8'h01, 8'h0F.
   - Response: stays all red. Then from green N, the same values hold green N indefinitely.
5. Request change during clearance:
   - Stimulus: pend=E latched; during yellow, laneRequest=8'h30.
   - Response: next green is 8'h0C, not S. S gets green only after a further 20+4+2 cycles.
   - Stimulus: rst pulse mid-yellow.
   - Response: next edge red=8'hFF, yellow=0.
6. MAX_GREEN_EN, MAX_GREEN=30:
   - Stimulus: laneRequest fixed at 8'h03.
   - Response: after 30 green cycles, yellow N, all-red, green E. After 20 cycles back to N via yellow E.
